// File: rtl/gate_response_checker_pkg.sv
// Shared types and constants for the gate response checker: FSM state
// encoding, obs bit positions and error counter width.
package gate_chk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  // Bit positions inside obs / expected, packed {i,h,g,f,e,d,c}
  localparam int C_IDX = 0;
  localparam int D_IDX = 1;
  localparam int E_IDX = 2;
  localparam int F_IDX = 3;
  localparam int G_IDX = 4;
  localparam int H_IDX = 5;
  localparam int I_IDX = 6;
  localparam int OBS_W = 7;

  localparam int ERR_W = 8;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

endpackage

// File: rtl/gate_golden_model.sv
// Combinational reference for the seven gates under test, driven by the
// same a/b the checker presents to the block.
module gate_golden_model
  import gate_chk_pkg::*;
(
  input  logic             a,
  input  logic             b,
  output logic [OBS_W-1:0] expected
);

  always_comb begin
    expected        = '0;
    expected[C_IDX] = a & b;
    expected[D_IDX] = a | b;
    expected[E_IDX] = ~(a & b);
    expected[F_IDX] = ~(a | b);
    expected[G_IDX] = a ^ b;
    expected[H_IDX] = ~(a ^ b);
    expected[I_IDX] = ~a;
  end

endmodule

// File: rtl/gate_response_checker.sv
// Sweeps {a,b} through 00..11 PASSES times, waits SETTLE_CYCLES per vector and
// counts mismatching obs samples. Define GATE_CHK_LOG_EN for first-failure capture.
module gate_response_checker
  import gate_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES        = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic [OBS_W-1:0] obs,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt
`ifdef GATE_CHK_LOG_EN
  ,
  output logic [1:0]       first_fail_vec,
  output logic [OBS_W-1:0] first_fail_mask
`endif
);

  state_t           state, state_nxt;
  logic [1:0]       vec_cnt;
  logic [7:0]       pass_cnt;
  logic [3:0]       settle_cnt;
  logic [OBS_W-1:0] expected;
  logic             accept;
  logic             settle_end;
  logic             last_vec;
  logic             mismatch;

  gate_golden_model u_gold (
    .a        (a),
    .b        (b),
    .expected (expected)
  );

  assign accept     = start && (state == ST_IDLE || state == ST_DONE);
  assign settle_end = (settle_cnt == 4'(SETTLE_CYCLES - 1));
  assign last_vec   = (vec_cnt == 2'b11) && (pass_cnt == 8'(PASSES - 1));
  assign mismatch   = (obs != expected);

  // The vector counter is the stimulus; it only moves on accept or leaving CHECK
  assign a = vec_cnt[1];
  assign b = vec_cnt[0];

  assign busy = (state == ST_DRIVE) || (state == ST_SETTLE) || (state == ST_CHECK);
  assign done = (state == ST_DONE);
  assign pass = done && (err_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE,
      ST_DONE:   if (accept) state_nxt = ST_DRIVE;
      ST_DRIVE:  state_nxt = ST_SETTLE;
      ST_SETTLE: if (settle_end) state_nxt = ST_CHECK;
      ST_CHECK:  state_nxt = last_vec ? ST_DONE : ST_DRIVE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec_cnt    <= '0;
      pass_cnt   <= '0;
      settle_cnt <= '0;
      err_cnt    <= '0;
    end else begin
      if (accept) begin
        vec_cnt  <= '0;
        pass_cnt <= '0;
        err_cnt  <= '0;
      end
      if (state == ST_SETTLE) settle_cnt <= settle_end ? 4'd0 : settle_cnt + 4'd1;
      else                    settle_cnt <= '0;
      if (state == ST_CHECK) begin
        if (mismatch && err_cnt != ERR_MAX) err_cnt <= err_cnt + 1'b1;
        vec_cnt <= vec_cnt + 2'd1;
        if (vec_cnt == 2'b11) pass_cnt <= pass_cnt + 8'd1;
      end
    end
  end

`ifdef GATE_CHK_LOG_EN
  // err_cnt still zero in CHECK means this is the run's first mismatch
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      first_fail_vec  <= '0;
      first_fail_mask <= '0;
    end else if (state == ST_CHECK && mismatch && err_cnt == '0) begin
      first_fail_vec  <= vec_cnt;
      first_fail_mask <= obs ^ expected;
    end
  end
`endif

endmodule

// File: tb/tb_gate_response_checker.sv
// Randomized bench for gate_response_checker: two instances (short run and
// 64-pass saturation run) checked every cycle against a timeline model.
module tb_gate_response_checker;

  localparam int SC [2] = '{2, 2};
  localparam int PC [2] = '{1, 64};

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] start;
  logic [1:0] a, b, busy, done, pass;
  logic [7:0] err_cnt [2];
  logic [6:0] obs [2];
  logic [6:0] fmask [2][4];
`ifdef GATE_CHK_LOG_EN
  logic [1:0] ffv [2];
  logic [6:0] ffm [2];
`endif

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [6:0] gold(input logic x, input logic y);
    int n;
    logic [6:0] r;
    n    = int'(x) + int'(y);
    r[0] = (n == 2);
    r[1] = (n >= 1);
    r[2] = (n != 2);
    r[3] = (n == 0);
    r[4] = (n == 1);
    r[5] = (n != 1);
    r[6] = !x;
    return r;
  endfunction

  assign obs[0] = gold(a[0], b[0]) ^ fmask[0][{a[0], b[0]}];
  assign obs[1] = gold(a[1], b[1]) ^ fmask[1][{a[1], b[1]}];

  gate_response_checker #(.SETTLE_CYCLES(SC[0]), .PASSES(PC[0])) dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .a(a[0]), .b(b[0]), .obs(obs[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_cnt(err_cnt[0])
`ifdef GATE_CHK_LOG_EN
    , .first_fail_vec(ffv[0]), .first_fail_mask(ffm[0])
`endif
  );

  gate_response_checker #(.SETTLE_CYCLES(SC[1]), .PASSES(PC[1])) dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .a(a[1]), .b(b[1]), .obs(obs[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_cnt(err_cnt[1])
`ifdef GATE_CHK_LOG_EN
    , .first_fail_vec(ffv[1]), .first_fail_mask(ffm[1])
`endif
  );

  task automatic check(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0d expected %0d at %0t", nm, d, act, exp, $time);
    end
  endtask

  // Model: a run is a timeline t = cycles since first DRIVE; vector and phase follow by division
  bit       m_act   [2] = '{0, 0};
  bit       m_done  [2] = '{0, 0};
  bit       m_fresh [2] = '{1, 1};
  int       m_t     [2] = '{0, 0};
  int       m_err   [2] = '{0, 0};
  int       m_ffv   [2] = '{0, 0};
  int       m_ffm   [2] = '{0, 0};

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_act[d] = 0; m_done[d] = 0; m_fresh[d] = 1; m_t[d] = 0;
        m_err[d] = 0; m_ffv[d] = 0; m_ffm[d] = 0;
      end else if (start[d] && !m_act[d]) begin
        m_act[d] = 1; m_done[d] = 0; m_fresh[d] = 0; m_t[d] = 0;
        m_err[d] = 0; m_ffv[d] = 0; m_ffm[d] = 0;
      end else if (m_act[d]) begin
        if (m_t[d] % (SC[d] + 2) == SC[d] + 1) begin
          int v;
          v = (m_t[d] / (SC[d] + 2)) % 4;
          if (fmask[d][v] != 0) begin
            if (m_err[d] == 0) begin
              m_ffv[d] = v;
              m_ffm[d] = int'(fmask[d][v]);
            end
            if (m_err[d] < 255) m_err[d]++;
          end
        end
        m_t[d]++;
        if (m_t[d] == 4 * PC[d] * (SC[d] + 2)) begin
          m_act[d]  = 0;
          m_done[d] = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        check("busy", d, busy[d], m_act[d]);
        check("done", d, done[d], m_done[d]);
        check("pass", d, pass[d], (m_done[d] && m_err[d] == 0));
        check("err_cnt", d, err_cnt[d], m_err[d]);
        if (m_act[d] || m_fresh[d]) begin
          int v;
          v = m_act[d] ? (m_t[d] / (SC[d] + 2)) % 4 : 0;
          check("a", d, a[d], (v >> 1) & 1);
          check("b", d, b[d], v & 1);
        end
`ifdef GATE_CHK_LOG_EN
        check("first_fail_vec", d, ffv[d], m_ffv[d]);
        check("first_fail_mask", d, ffm[d], m_ffm[d]);
`endif
      end
    end
  end

  // Pulse start, then walk the run counting busy cycles; optional stray start / reset
  task automatic do_run(input int d, input int bound, input int extra_at, input int rst_at,
                        input bit rst_ws, output int bc);
    bit aborted;
    aborted = 0;
    @(negedge clk); start[d] = 1'b1;
    @(negedge clk); start[d] = 1'b0;
    bc = 0;
    for (int i = 0; i < bound; i++) begin
      if (done[d]) break;
      if (busy[d]) bc++;
      if (i == rst_at) begin
        rst = 1'b1; start[d] = rst_ws;
        @(negedge clk);
        rst = 1'b0; start[d] = 1'b0;
        aborted = 1;
        break;
      end
      start[d] = (i == extra_at);
      @(negedge clk);
    end
    start[d] = 1'b0;
    if (!aborted && !done[d]) check("run_timeout", d, 0, 1);
  endtask

  int bc;

  initial begin
    rst = 1'b1;
    start = '0;
    for (int d = 0; d < 2; d++) for (int v = 0; v < 4; v++) fmask[d][v] = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_busy", 0, busy[0], 0);
    check("rst_err", 1, err_cnt[1], 0);
    check("rst_ab", 0, {a[0], b[0]}, 0);
    rst = 1'b0;

    // Correct gates: 16 busy cycles, clean pass
    do_run(0, 40, -1, -1, 0, bc);
    check("lat_good", 0, bc, 16);
    check("err_good", 0, err_cnt[0], 0);
    check("pass_good", 0, pass[0], 1);

    // c stuck at 0 only differs on vector 11; stray start in SETTLE is ignored
    fmask[0][3] = 7'b0000001;
    do_run(0, 40, 2, -1, 0, bc);
    check("lat_stuck", 0, bc, 16);
    check("err_stuck", 0, err_cnt[0], 1);
    check("pass_stuck", 0, pass[0], 0);
`ifdef GATE_CHK_LOG_EN
    check("ffv_stuck", 0, ffv[0], 3);
    check("ffm_stuck", 0, ffm[0], 1);
`endif
    // Restart from DONE: count cleared, run repeats identically
    do_run(0, 40, -1, -1, 0, bc);
    check("lat_rerun", 0, bc, 16);
    check("err_rerun", 0, err_cnt[0], 1);

    // All obs inverted over 64 passes: 256 mismatches saturate at 255
    for (int v = 0; v < 4; v++) fmask[1][v] = 7'h7f;
    do_run(1, 1100, 500, -1, 0, bc);
    check("lat_sat", 1, bc, 1024);
    check("err_sat", 1, err_cnt[1], 255);
    check("pass_sat", 1, pass[1], 0);
`ifdef GATE_CHK_LOG_EN
    check("ffm_sat", 1, ffm[1], 7'h7f);
`endif

    // Reset with start during the first CHECK: abort, sample not counted
    for (int v = 0; v < 4; v++) fmask[0][v] = 7'h7f;
    do_run(0, 40, -1, 3, 1, bc);
    check("abort_busy", 0, busy[0], 0);
    check("abort_err", 0, err_cnt[0], 0);
    check("abort_done", 0, done[0], 0);

    repeat (40) begin
      int ra;
      for (int v = 0; v < 4; v++)
        fmask[0][v] = ($urandom_range(0, 1) == 1) ? 7'($urandom) : 7'h00;
      ra = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 17)) : -1;
      do_run(0, 40, int'($urandom_range(0, 25)), ra, 1'($urandom_range(0, 1)), bc);
      if (ra < 0) check("lat_rand", 0, bc, 16);
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
